// File: rtl/audio_frame_sequencer.sv
// Per-sample scheduler: starts an SPI capture each frame, hands the word to the DSP, and parks
// the result in a one-word buffer that the I2S side drains. Overrun/timeout/underrun are counted.
module audio_frame_sequencer #(
    parameter int DATA_W         = 16,
    parameter int CLK_PER_SAMPLE = 256,
    parameter int DSP_TIMEOUT    = 64
) (
    input  logic              input_clk,
    input  logic              reset,
    input  logic              enable,
    output logic              cap_start,
    input  logic              cap_valid,
    input  logic [DATA_W-1:0] cap_data,
    output logic              dsp_start,
    output logic [DATA_W-1:0] dsp_data,
    input  logic              dsp_done,
    input  logic [DATA_W-1:0] dsp_result,
    input  logic              tx_ready,
    output logic              tx_load,
    output logic [DATA_W-1:0] tx_data,
    output logic              frame_tick,
    output logic [1:0]        state,
    output logic [7:0]        overrun_cnt,
    output logic [7:0]        timeout_cnt,
    output logic [7:0]        underrun_cnt
);

    localparam int FC_W = (CLK_PER_SAMPLE > 1) ? $clog2(CLK_PER_SAMPLE) : 1;
    localparam int TO_W = $clog2(DSP_TIMEOUT) + 1;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_CAPTURE = 2'd1,
        S_PROCESS = 2'd2,
        S_HOLD    = 2'd3
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [FC_W-1:0]   r_frame_cnt;
    logic [TO_W-1:0]   r_to_cnt;
    logic [DATA_W-1:0] r_dsp_data;
    logic [DATA_W-1:0] r_out_buf;
    logic [DATA_W-1:0] r_tx_data;
    logic              r_buf_valid;
    logic              r_cap_start;
    logic              r_frame_tick;
    logic              r_dsp_start;
    logic              r_tx_load;
    logic [7:0]        r_overrun_cnt;
    logic [7:0]        r_timeout_cnt;
    logic [7:0]        r_underrun_cnt;

    logic w_frame_start;
    logic w_active;
    logic w_accept_cap;
    logic w_accept_done;
    logic w_timeout;
    logic w_overrun;
    logic w_underrun;

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    // A frame start preempts everything else in the FSM, so capture/done/timeout only act when absent.
    assign w_frame_start = enable && (r_frame_cnt == '0);
    assign w_active      = enable && !w_frame_start;
    assign w_accept_cap  = w_active && (r_state == S_CAPTURE) && cap_valid;
    assign w_accept_done = w_active && (r_state == S_PROCESS) && dsp_done;
    assign w_timeout     = w_active && (r_state == S_PROCESS) && !dsp_done
                           && (r_to_cnt == TO_W'(DSP_TIMEOUT - 1));
    assign w_overrun     = w_frame_start && ((r_state == S_CAPTURE) || (r_state == S_PROCESS));
    assign w_underrun    = enable && tx_ready && !w_accept_done && !r_buf_valid;

    always_comb begin
        w_state_nxt = r_state;
        if (!enable) begin
            w_state_nxt = S_IDLE;
        end else if (w_frame_start) begin
            w_state_nxt = S_CAPTURE;
        end else begin
            case (r_state)
                S_CAPTURE: if (w_accept_cap) w_state_nxt = S_PROCESS;
                S_PROCESS: if (w_accept_done || w_timeout) w_state_nxt = S_HOLD;
                default:   w_state_nxt = r_state;
            endcase
        end
    end

    always_ff @(posedge input_clk or negedge reset) begin
        if (!reset) begin
            r_state     <= S_IDLE;
            r_frame_cnt <= '0;
            r_to_cnt    <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (!enable || (r_frame_cnt == FC_W'(CLK_PER_SAMPLE - 1)))
                r_frame_cnt <= '0;
            else
                r_frame_cnt <= r_frame_cnt + 1'b1;
            if (w_accept_cap)
                r_to_cnt <= '0;
            else if (r_state == S_PROCESS)
                r_to_cnt <= r_to_cnt + 1'b1;
        end
    end

    always_ff @(posedge input_clk or negedge reset) begin
        if (!reset) begin
            r_cap_start    <= 1'b0;
            r_frame_tick   <= 1'b0;
            r_dsp_start    <= 1'b0;
            r_dsp_data     <= '0;
            r_tx_load      <= 1'b0;
            r_tx_data      <= '0;
            r_out_buf      <= '0;
            r_buf_valid    <= 1'b0;
            r_overrun_cnt  <= '0;
            r_timeout_cnt  <= '0;
            r_underrun_cnt <= '0;
        end else begin
            r_cap_start  <= w_frame_start;
            r_frame_tick <= w_frame_start;
            r_dsp_start  <= w_accept_cap;
            r_tx_load    <= tx_ready;
            if (w_accept_cap)
                r_dsp_data <= cap_data;
            // A result arriving with tx_ready bypasses the buffer; otherwise the newest result wins.
            if (tx_ready) begin
                if (w_accept_done)
                    r_tx_data <= dsp_result;
                else if (r_buf_valid)
                    r_tx_data <= r_out_buf;
                r_buf_valid <= 1'b0;
            end else if (w_accept_done) begin
                r_out_buf   <= dsp_result;
                r_buf_valid <= 1'b1;
            end
            if (w_overrun)
                r_overrun_cnt <= sat_inc(r_overrun_cnt);
            if (w_timeout)
                r_timeout_cnt <= sat_inc(r_timeout_cnt);
            if (w_underrun)
                r_underrun_cnt <= sat_inc(r_underrun_cnt);
        end
    end

    assign cap_start    = r_cap_start;
    assign frame_tick   = r_frame_tick;
    assign dsp_start    = r_dsp_start;
    assign dsp_data     = r_dsp_data;
    assign tx_load      = r_tx_load;
    assign tx_data      = r_tx_data;
    assign state        = r_state;
    assign overrun_cnt  = r_overrun_cnt;
    assign timeout_cnt  = r_timeout_cnt;
    assign underrun_cnt = r_underrun_cnt;

endmodule
